// File: rtl/shoot_ctrl.sv
// Fire-key to bullet-slot launch controller: synchronises the key and the game tick, enforces a
// cooldown and emits a one-hot shoot strobe with spawn position. Optional: SHOOT_AUTOFIRE_EN.
module shoot_ctrl #(
  parameter int unsigned Slots    = 4,
  parameter int unsigned Cooldown = 8,
  parameter int unsigned KidW     = 12,
  parameter int unsigned BulletW  = 4,
  parameter int unsigned YOff     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             update_clk_i,
  input  logic             key_shoot_i,
  input  logic [9:0]       kid_x_i,
  input  logic [9:0]       kid_y_i,
  input  logic             kid_dir_i,
  input  logic [Slots-1:0] slot_busy_i,
  output logic [Slots-1:0] shoot_o,
  output logic [9:0]       spawn_x_o,
  output logic [9:0]       spawn_y_o,
  output logic             spawn_dir_o,
  output logic [7:0]       shot_count_o
);

  localparam int unsigned PtrW = (Slots > 1) ? $clog2(Slots) : 1;
  localparam int unsigned CdW  = (Cooldown > 0) ? $clog2(Cooldown + 1) : 1;

  // ARM has no dwell time: its actions happen on the IDLE tick that leaves for FIRE.
  typedef enum logic [1:0] {StIdle, StFire, StCool} state_e;

  state_e           state_q, state_d;
  logic             key_s1_q, key_s2_q, key_prev_q;
  logic             upd_s1_q, upd_s2_q, upd_prev_q;
  logic             pending_q, pending_d;
  logic [CdW-1:0]   cd_q, cd_d;
  logic [PtrW-1:0]  rr_q, rr_d;
  logic [Slots-1:0] shoot_q, shoot_d;
  logic [9:0]       spawn_x_q, spawn_x_d;
  logic [9:0]       spawn_y_q, spawn_y_d;
  logic             spawn_dir_q, spawn_dir_d;
  logic [7:0]       count_q, count_d;

  logic             press, tick, arm_req;
  logic [PtrW-1:0]  sel;
  int               scan_idx;
  logic [10:0]      right_x;
  logic [9:0]       spawn_x_new;

  assign press = key_s2_q & ~key_prev_q;
  assign tick  = upd_s2_q & ~upd_prev_q;

`ifdef SHOOT_AUTOFIRE_EN
  assign arm_req = key_s2_q;
`else
  assign arm_req = press;
`endif

  // First free slot at or after rr_q (circularly); rr_q itself when all are busy.
  always_comb begin
    sel      = rr_q;
    scan_idx = 0;
    for (int k = int'(Slots) - 1; k >= 0; k--) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= int'(Slots)) begin
        scan_idx = scan_idx - int'(Slots);
      end
      if (!slot_busy_i[scan_idx]) begin
        sel = PtrW'(scan_idx);
      end
    end
  end

  assign right_x = {1'b0, kid_x_i} + 11'(KidW);

  always_comb begin
    spawn_x_new = '0;
    if (kid_dir_i) begin
      spawn_x_new = right_x[10] ? 10'd1023 : right_x[9:0];
    end else if (kid_x_i >= 10'(BulletW)) begin
      spawn_x_new = kid_x_i - 10'(BulletW);
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    cd_d        = cd_q;
    rr_d        = rr_q;
    shoot_d     = shoot_q;
    spawn_x_d   = spawn_x_q;
    spawn_y_d   = spawn_y_q;
    spawn_dir_d = spawn_dir_q;
    count_d     = count_q;

    if (state_q == StIdle && arm_req) begin
      pending_d = 1'b1;
    end

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (pending_q) begin
            pending_d   = 1'b0;
            shoot_d     = Slots'(1) << sel;
            spawn_x_d   = spawn_x_new;
            spawn_y_d   = kid_y_i + 10'(YOff);
            spawn_dir_d = kid_dir_i;
            count_d     = count_q + 8'd1;
            rr_d        = (sel == PtrW'(Slots - 1)) ? '0 : sel + PtrW'(1);
            state_d     = StFire;
          end
        end
        StFire: begin
          shoot_d = '0;
          if (Cooldown == 0) begin
            cd_d    = '0;
            state_d = StIdle;
          end else begin
            cd_d    = CdW'(Cooldown);
            state_d = StCool;
          end
        end
        StCool: begin
          // The tick that drains the counter also returns to IDLE: COOLDOWN ticks in COOL.
          if (cd_q <= CdW'(1)) begin
            cd_d    = '0;
            state_d = StIdle;
          end else begin
            cd_d = cd_q - CdW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_s1_q    <= 1'b0;
      key_s2_q    <= 1'b0;
      key_prev_q  <= 1'b0;
      upd_s1_q    <= 1'b0;
      upd_s2_q    <= 1'b0;
      upd_prev_q  <= 1'b0;
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      cd_q        <= '0;
      rr_q        <= '0;
      shoot_q     <= '0;
      spawn_x_q   <= '0;
      spawn_y_q   <= '0;
      spawn_dir_q <= 1'b1;
      count_q     <= '0;
    end else begin
      key_s1_q    <= key_shoot_i;
      key_s2_q    <= key_s1_q;
      key_prev_q  <= key_s2_q;
      upd_s1_q    <= update_clk_i;
      upd_s2_q    <= upd_s1_q;
      upd_prev_q  <= upd_s2_q;
      state_q     <= state_d;
      pending_q   <= pending_d;
      cd_q        <= cd_d;
      rr_q        <= rr_d;
      shoot_q     <= shoot_d;
      spawn_x_q   <= spawn_x_d;
      spawn_y_q   <= spawn_y_d;
      spawn_dir_q <= spawn_dir_d;
      count_q     <= count_d;
    end
  end

  assign shoot_o      = shoot_q;
  assign spawn_x_o    = spawn_x_q;
  assign spawn_y_o    = spawn_y_q;
  assign spawn_dir_o  = spawn_dir_q;
  assign shot_count_o = count_q;

endmodule

// File: tb/tb_shoot_ctrl.sv
// Scoreboard bench for shoot_ctrl: expected launches are queued at stimulus time and checked
// by a monitor when shoot rises; also checks one-edge width, cooldown, reset and wrap.
module tb_shoot_ctrl;
  localparam int SLOTS    = 4;
  localparam int COOLDOWN = 8;

  logic       clk, rst, update_clk, key_shoot;
  logic [9:0] kid_x, kid_y;
  logic       kid_dir;
  logic [3:0] slot_busy;
  logic [3:0] shoot;
  logic [9:0] spawn_x, spawn_y;
  logic       spawn_dir;
  logic [7:0] shot_count;

  shoot_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .update_clk_i (update_clk),
    .key_shoot_i  (key_shoot),
    .kid_x_i      (kid_x),
    .kid_y_i      (kid_y),
    .kid_dir_i    (kid_dir),
    .slot_busy_i  (slot_busy),
    .shoot_o      (shoot),
    .spawn_x_o    (spawn_x),
    .spawn_y_o    (spawn_y),
    .spawn_dir_o  (spawn_dir),
    .shot_count_o (shot_count)
  );

  typedef struct {
    logic [3:0] shoot;
    int         x;
    int         y;
    bit         dir;
    int         cnt;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  time        rise_t[$];
  int         nchecks = 0;
  int         nerr = 0;
  int         n_obs = 0;
  int         hi_edges = 0;
  int         m_rr = 0;
  int         m_cnt = 0;
  logic [3:0] shoot_prev = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    update_clk = 1'b0;
    #3;
    forever #50 update_clk = ~update_clk;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input string info);
    nchecks++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  // Reference: the next launch from game rules on the current kid/slot situation.
  function automatic void predict(input int x, input int y, input bit dir, input logic [3:0] busy);
    exp_t e;
    int   slot;
    bit   found;
    slot  = m_rr;
    found = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (!found && !busy[(m_rr + k) % SLOTS]) begin
        slot  = (m_rr + k) % SLOTS;
        found = 1'b1;
      end
    end
    e.shoot = 4'(1 << slot);
    e.dir   = dir;
    e.y     = (y + 8) % 1024;
    if (dir) e.x = (x + 12 > 1023) ? 1023 : x + 12;
    else     e.x = (x < 4) ? 0 : x - 4;
    m_cnt   = (m_cnt + 1) % 256;
    e.cnt   = m_cnt;
    m_rr    = (slot + 1) % SLOTS;
    exp_q.push_back(e);
  endfunction

  always @(posedge update_clk) begin
    if (!rst && shoot != 4'b0) hi_edges++;
  end

  always @(negedge clk) begin
    if (rst) begin
      shoot_prev = '0;
    end else begin
      if (shoot != 4'b0 && shoot_prev == 4'b0) begin
        n_obs++;
        hi_edges = 0;
        rise_t.push_back($time);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_shot", $sformatf("got shoot=%b, required no shot", shoot));
        end else begin
          mon_e = exp_q.pop_front();
          check(shoot == mon_e.shoot && spawn_x == mon_e.x && spawn_y == mon_e.y &&
                spawn_dir == mon_e.dir && shot_count == mon_e.cnt, "shot",
                $sformatf("got shoot=%b x=%0d y=%0d dir=%0d cnt=%0d, required shoot=%b x=%0d y=%0d dir=%0d cnt=%0d",
                          shoot, spawn_x, spawn_y, spawn_dir, shot_count,
                          mon_e.shoot, mon_e.x, mon_e.y, mon_e.dir, mon_e.cnt));
        end
      end else if (shoot == 4'b0 && shoot_prev != 4'b0) begin
        check(hi_edges == 1, "one_edge",
              $sformatf("shoot high across %0d update edges, required 1", hi_edges));
      end
      shoot_prev = shoot;
    end
  end

  task automatic press();
    @(negedge update_clk);
    #7 key_shoot = 1'b1;
    repeat (4) @(posedge clk);
    #2 key_shoot = 1'b0;
  endtask

  task automatic wait_shots(input int target, input string name);
    int n;
    n = 0;
    while (n_obs < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(n_obs >= target, name, $sformatf("observed %0d shots, required %0d", n_obs, target));
  endtask

  task automatic set_kid(input int x, input int y, input bit dir, input logic [3:0] busy);
    kid_x     = 10'(x);
    kid_y     = 10'(y);
    kid_dir   = dir;
    slot_busy = busy;
  endtask

  task automatic fire(input int x, input int y, input bit dir, input logic [3:0] busy);
    int target;
    target = n_obs + 1;
    set_kid(x, y, dir, busy);
    predict(x, y, dir, busy);
    press();
    wait_shots(target, "shot_timeout");
    repeat (COOLDOWN + 1) @(posedge update_clk);
  endtask

  initial begin
    int n0;
    int hold_shots;
    int bx[6];
    bx = '{0, 3, 4, 1011, 1012, 1023};
    rst = 1'b1;
    key_shoot = 1'b0;
    set_kid(0, 0, 1'b1, 4'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check(shoot == 4'b0, "rst_shoot", $sformatf("got %b, required 0000", shoot));
    check(shot_count == 8'd0, "rst_count", $sformatf("got %0d, required 0", shot_count));
    check(spawn_dir == 1'b1, "rst_dir", $sformatf("got %0d, required 1", spawn_dir));
    check(spawn_x == 10'd0 && spawn_y == 10'd0, "rst_spawn",
          $sformatf("got (%0d,%0d), required (0,0)", spawn_x, spawn_y));
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge update_clk);
    repeat (3) @(posedge clk);
    #1 check(n_obs == 0 && shoot == 4'b0, "idle_no_shot",
             $sformatf("got %0d shots shoot=%b, required 0 shots", n_obs, shoot));

    // Directed launches: first shot, left clamp, busy skip, all-busy reuse, boundaries
    fire(100, 200, 1'b1, 4'b0000);
    check(shot_count == 8'd1, "count_first", $sformatf("got %0d, required 1", shot_count));
    fire(2, 50, 1'b0, 4'b0010);
    fire(500, 300, 1'b1, 4'b1111);
    fire(1011, 1020, 1'b1, 4'b0000);
    fire(1012, 1015, 1'b1, 4'b0001);
    fire(4, 7, 1'b0, 4'b0100);
    fire(3, 0, 1'b0, 4'b1111);

    // A press during cooldown is dropped; the next press after IDLE fires
    n0 = n_obs;
    set_kid(300, 100, 1'b1, 4'b1111);
    predict(300, 100, 1'b1, 4'b1111);
    press();
    wait_shots(n0 + 1, "cool_first_timeout");
    repeat (2) @(posedge update_clk);
    press();
    repeat (COOLDOWN + 4) @(posedge update_clk);
    check(n_obs == n0 + 1 && exp_q.size() == 0, "cool_press_ignored",
          $sformatf("got %0d shots, required %0d", n_obs - n0, 1));
    fire(640, 480, 1'b0, 4'b0000);

    // Key held for 39 ticks
`ifdef SHOOT_AUTOFIRE_EN
    hold_shots = 4;
`else
    hold_shots = 1;
`endif
    n0 = n_obs;
    rise_t.delete();
    set_kid(200, 200, 1'b1, 4'b0110);
    for (int i = 0; i < hold_shots; i++) predict(200, 200, 1'b1, 4'b0110);
    @(negedge update_clk);
    #7 key_shoot = 1'b1;
    repeat (39) @(posedge update_clk);
    @(negedge update_clk);
    key_shoot = 1'b0;
    repeat (12) @(posedge update_clk);
    check(n_obs == n0 + hold_shots, "hold_shots",
          $sformatf("got %0d shots, required %0d", n_obs - n0, hold_shots));
`ifdef SHOOT_AUTOFIRE_EN
    for (int i = 1; i < rise_t.size(); i++) begin
      check(rise_t[i] - rise_t[i-1] == 1000, "autofire_period",
            $sformatf("got %0t apart, required 1000", rise_t[i] - rise_t[i-1]));
    end
`endif

    // Random launches with boundary x values mixed in
    for (int i = 0; i < 20; i++) begin
      fire((i % 3 == 0) ? bx[$urandom_range(0, 5)] : int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // Reset while shoot is high
    n0 = n_obs;
    set_kid(50, 60, 1'b0, 4'b0000);
    predict(50, 60, 1'b0, 4'b0000);
    press();
    wait_shots(n0 + 1, "pre_reset_timeout");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check(shoot == 4'b0 && shot_count == 8'd0 && spawn_dir == 1'b1 && spawn_x == 10'd0 &&
          spawn_y == 10'd0, "reset_mid_shot",
          $sformatf("got shoot=%b cnt=%0d dir=%0d x=%0d y=%0d, required 0000/0/1/0/0",
                    shoot, shot_count, spawn_dir, spawn_x, spawn_y));
    m_rr  = 0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge update_clk);

    // 256 shots wrap the counter
    for (int i = 0; i < 256; i++) begin
      fire(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    check(shot_count == 8'd0, "count_wrap", $sformatf("got %0d, required 0", shot_count));
    check(exp_q.size() == 0, "drain", $sformatf("%0d launches never seen, required 0", exp_q.size()));

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
